dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed data memory (1-cycle synchronous read) between the pipeline's load/store port (core) and a DMA/loader port (dma).
- Grants one request per cycle and drives the memory command.
- Tracks read ownership and routes read data back to the correct requester one cycle later.
- Rejects out-of-range and misaligned accesses with an error response, so illegal accesses never reach memory.

Parameters:
- DMEM_BASE, 32'h1000_0000, first byte address of data memory.
- DMEM_BYTES, 131072, data memory size in bytes.
- UART_TX_ADDR, 32'h2000_0000, write-only UART TX address; legal only for core stores.
- CORE_PRIO, 1, 1 = core has fixed priority with starvation guard; 0 = round robin.
- STARVE_MAX, 4, consecutive cycles dma may lose before it is forced a grant (CORE_PRIO=1 only); range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  core request valid; held with fields stable until core_gnt.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, LSB-aligned.
- core_size  in  2  00 byte, 01 half, 1x word.
- core_signed  in  1  sign-extend loads.
- core_gnt  out  1  request accepted this cycle (combinational).
- core_rvalid  out  1  response valid (registered).
- core_rdata  out  32  load data (registered).
- core_err  out  1  response is an error; qualifies core_rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_size, dma_signed, dma_gnt, dma_rvalid, dma_rdata, dma_err: same as the core_* ports, for the dma requester.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory store data.
- mem_size  out  2  load/store size to memory.
- mem_signed  out  1  load sign control to memory.
- mem_rdata  in  32  memory read data, valid the cycle after mem_read.

Behaviour:
- Reset (async, while rst=1):
  - gnt outputs forced 0, so mem_read and mem_write are 0.
  - rvalid, err and rdata registers 0.
  - rr_last = dma, so core wins the first contest.
  - starve_cnt = 0; rd_owner_v = 0.
- Arbitration (combinational, every cycle):
  - CORE_PRIO=1: core wins unless starve_cnt == STARVE_MAX and dma_req=1.
  - CORE_PRIO=0: on contention the requester other than rr_last wins; rr_last updates on every grant.
  - Exactly one gnt at most per cycle; gnt=1 only when the matching req=1.
- starve_cnt:
  - Increments when dma_req=1 and dma loses; saturates at STARVE_MAX.
  - Clears on any dma grant or when dma_req=0.
- Legality check on the winning request (combinational):
  - in_dmem: addr ≥ DMEM_BASE and (addr − DMEM_BASE + bytes − 1) < DMEM_BYTES.
  - Aligned: half needs addr[0]=0; word needs addr[1:0]=0.
  - Core store to UART_TX_ADDR is legal with any size; only wdata[7:0] is meaningful.
  - Dma access to the UART address is illegal.
- Legal grant:
  - mem_read = ~we, mem_write = we.
  - addr, wdata, size and signed forwarded unmodified in the same cycle.
- Illegal grant:
  - Granted (so the requester does not hang) with mem_read = mem_write = 0.
  - Requester sees rvalid=1, err=1, rdata=0 next cycle.
- Responses:
  - Load: next cycle the owner's rvalid=1 and rdata = mem_rdata (registered capture).
  - Store: next cycle the owner's rvalid=1 and err=0; rdata unchanged.
  - Owner and kind are registered at grant in rd_owner / rd_owner_v.
  - rvalid is a 1-cycle pulse; there is no backpressure on responses.
- Throughput: back-to-back grants every cycle, including alternating requesters; response latency is fixed at 1 cycle.
- Request removed without a grant: legal; no memory side effect.
- Reset asserted mid-operation: the in-flight response is dropped (rvalid stays 0); the memory write issued that cycle is not cancelled.

Decomposition:
- Shared package dmem_pkg holds:
  - DMEM_BASE, DMEM_BYTES and UART_TX_ADDR constants.
  - Size encodings SZ_B / SZ_H / SZ_W.
  - Requester ID enum REQ_CORE / REQ_DMA.
- One sub-module: dmem_addr_check, a combinational legality check (addr, size, we, is_core → ok).

Test Plan:
1. Core LW 0x1000_0004, memory word 0xDEADBEEF → core_gnt same cycle, mem_read=1; next cycle core_rvalid=1, core_rdata=0xDEADBEEF, core_err=0.
2. Core and dma both request continuously with CORE_PRIO=1, STARVE_MAX=4 → grant pattern core×4, dma, core×4, dma…; dma never waits more than 4 cycles.
3. CORE_PRIO=0, both requesting continuously → strict alternation core, dma, core…; each response arrives at the correct port.
4. Dma LH 0x1000_0003 (misaligned) → dma_gnt=1 with mem_read=0; next cycle dma_rvalid=1, dma_err=1, dma_rdata=0.
5. Core SB 0x2000_0000 with wdata 0x41 → mem_write=1, mem_addr=0x2000_0000; dma SW to the same address → err=1, mem_write=0.
6. Grant a core LW, assert rst in the next cycle → core_rvalid stays 0; after release, core wins the first contest against dma.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory map, access size encodings and requester IDs.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE    = 32'h1000_0000;
  localparam int unsigned DMEM_BYTES   = 131072;
  localparam logic [31:0] UART_TX_ADDR = 32'h2000_0000;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_e;

  // Number of bytes touched by an access; any size with bit 1 set is a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    if (size[1]) return 3'd4;
    if (size[0]) return 3'd2;
    return 3'd1;
  endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational legality check for one memory access.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE  = DMEM_BASE,
  parameter int unsigned BYTES = DMEM_BYTES,
  parameter logic [31:0] UART  = UART_TX_ADDR
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic        is_core,
  output logic        ok
);

  logic [33:0] last_off;
  logic        in_dmem;
  logic        aligned;
  logic        uart_ok;

  // Range, alignment and UART-store rules; extra width keeps the end offset from wrapping.
  always_comb begin
    last_off = {2'b00, addr} - {2'b00, BASE} + 34'(size_bytes(size)) - 34'd1;
    in_dmem  = (addr >= BASE) && (last_off < 34'(BYTES));
    if (size[1])      aligned = (addr[1:0] == 2'b00);
    else if (size[0]) aligned = ~addr[0];
    else              aligned = 1'b1;
    uart_ok  = is_core && we && (addr == UART);
    ok       = uart_ok || (in_dmem && aligned);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory with 1-cycle responses.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE    = dmem_pkg::DMEM_BASE,
  parameter int unsigned DMEM_BYTES   = dmem_pkg::DMEM_BYTES,
  parameter logic [31:0] UART_TX_ADDR = dmem_pkg::UART_TX_ADDR,
  parameter bit          CORE_PRIO    = 1'b1,
  parameter int unsigned STARVE_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_size,
  input  logic        core_signed,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_size,
  input  logic        dma_signed,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_signed,
  input  logic [31:0] mem_rdata
);

  dmem_pkg::req_id_e rr_last;
  dmem_pkg::req_id_e rd_owner;
  logic              rd_owner_v;
  logic              rd_err;
  logic              rd_load;
  logic [3:0]        starve_cnt;
  logic [31:0]       core_rdata_q;
  logic [31:0]       dma_rdata_q;
  logic              sel_we;
  logic              ok;
  logic              any_gnt;
  logic              core_rsp;
  logic              dma_rsp;

  // Pick at most one winner; nothing is granted while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst) begin
      if (CORE_PRIO) begin
        if (dma_req && (starve_cnt == 4'(STARVE_MAX))) dma_gnt  = 1'b1;
        else if (core_req)                             core_gnt = 1'b1;
        else if (dma_req)                              dma_gnt  = 1'b1;
      end else if (core_req && dma_req) begin
        if (rr_last == dmem_pkg::REQ_DMA) core_gnt = 1'b1;
        else                              dma_gnt  = 1'b1;
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end
  end

  // Forward the winner's command; illegal accesses get no strobe.
  always_comb begin
    any_gnt    = core_gnt | dma_gnt;
    sel_we     = dma_gnt ? dma_we     : core_we;
    mem_addr   = dma_gnt ? dma_addr   : core_addr;
    mem_wdata  = dma_gnt ? dma_wdata  : core_wdata;
    mem_size   = dma_gnt ? dma_size   : core_size;
    mem_signed = dma_gnt ? dma_signed : core_signed;
    mem_read   = any_gnt && ok && !sel_we;
    mem_write  = any_gnt && ok && sel_we;
  end

  dmem_addr_check #(
    .BASE  (DMEM_BASE),
    .BYTES (DMEM_BYTES),
    .UART  (UART_TX_ADDR)
  ) u_addr_check (
    .addr    (mem_addr),
    .size    (mem_size),
    .we      (sel_we),
    .is_core (~dma_gnt),
    .ok      (ok)
  );

  // Fairness state: dma starvation counter and last round-robin winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      rr_last    <= dmem_pkg::REQ_DMA;
    end else begin
      if (!dma_req || dma_gnt)               starve_cnt <= 4'd0;
      else if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
      if (core_gnt)     rr_last <= dmem_pkg::REQ_CORE;
      else if (dma_gnt) rr_last <= dmem_pkg::REQ_DMA;
    end
  end

  // Remember who owns next cycle's response and what kind it is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_v <= 1'b0;
      rd_owner   <= dmem_pkg::REQ_CORE;
      rd_err     <= 1'b0;
      rd_load    <= 1'b0;
    end else begin
      rd_owner_v <= any_gnt;
      rd_owner   <= dma_gnt ? dmem_pkg::REQ_DMA : dmem_pkg::REQ_CORE;
      rd_err     <= !ok;
      rd_load    <= ok && !sel_we;
    end
  end

  // Hold last load data per port; an error response zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata_q <= 32'd0;
      dma_rdata_q  <= 32'd0;
    end else begin
      if (core_gnt && !ok)       core_rdata_q <= 32'd0;
      else if (core_rsp && rd_load) core_rdata_q <= mem_rdata;
      if (dma_gnt && !ok)        dma_rdata_q <= 32'd0;
      else if (dma_rsp && rd_load)  dma_rdata_q <= mem_rdata;
    end
  end

  // Route the response to its owner; load data comes straight from the memory's output register.
  always_comb begin
    core_rsp    = rd_owner_v && (rd_owner == dmem_pkg::REQ_CORE);
    dma_rsp     = rd_owner_v && (rd_owner == dmem_pkg::REQ_DMA);
    core_rvalid = core_rsp;
    dma_rvalid  = dma_rsp;
    core_err    = core_rsp && rd_err;
    dma_err     = dma_rsp && rd_err;
    core_rdata  = (core_rsp && rd_load) ? mem_rdata : core_rdata_q;
    dma_rdata   = (dma_rsp && rd_load) ? mem_rdata : dma_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus random traffic against a reference model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        core_req, core_we, core_signed, core_gnt, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [1:0]  core_size;
  logic        dma_req, dma_we, dma_signed, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [1:0]  dma_size;
  logic        mem_read, mem_write, mem_signed;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  mem_size;

  logic        rr_core_req, rr_dma_req;
  logic        rr_core_gnt, rr_core_rvalid, rr_core_err, rr_dma_gnt, rr_dma_rvalid, rr_dma_err;
  logic [31:0] rr_core_rdata, rr_dma_rdata;
  logic        rr_mem_read, rr_mem_write, rr_mem_signed;
  logic [31:0] rr_mem_addr, rr_mem_wdata;
  logic [31:0] rr_mem_rdata = 32'd0;
  logic [1:0]  rr_mem_size;

  dmem_arbiter #(.CORE_PRIO(1'b1), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_size(core_size), .core_signed(core_signed), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_signed(dma_signed), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_signed(mem_signed), .mem_rdata(mem_rdata)
  );

  // Round-robin instance: both ports load fixed addresses.
  dmem_arbiter #(.CORE_PRIO(1'b0), .STARVE_MAX(SMAX)) u_rr (
    .clk(clk), .rst(rst),
    .core_req(rr_core_req), .core_we(1'b0), .core_addr(32'h1000_0040),
    .core_wdata(32'd0), .core_size(SZ_W), .core_signed(1'b0), .core_gnt(rr_core_gnt),
    .core_rvalid(rr_core_rvalid), .core_rdata(rr_core_rdata), .core_err(rr_core_err),
    .dma_req(rr_dma_req), .dma_we(1'b0), .dma_addr(32'h1000_0080),
    .dma_wdata(32'd0), .dma_size(SZ_W), .dma_signed(1'b0), .dma_gnt(rr_dma_gnt),
    .dma_rvalid(rr_dma_rvalid), .dma_rdata(rr_dma_rdata), .dma_err(rr_dma_err),
    .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_size(rr_mem_size), .mem_signed(rr_mem_signed),
    .mem_rdata(rr_mem_rdata)
  );

  // Word memory behind the main DUT; untouched words read a pattern from their address.
  logic [31:0] tbmem [int unsigned];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (tbmem.exists(a[31:2])) return tbmem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h3C3C_A5A5;
  endfunction
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem_word(mem_addr);
    if (mem_write) tbmem[mem_addr[31:2]] = mem_wdata;
  end
  always @(posedge clk) if (rr_mem_read) rr_mem_rdata <= rr_mem_addr ^ 32'h5A5A_5A5A;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int unsigned dma_wait;
  bit          exp_c_v, exp_c_err, exp_d_v, exp_d_err;
  logic [31:0] c_hold, d_hold;
  bit          c_pend, d_pend;
  bit          obs_dgnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [1:0] sz, input bit we,
                               input bit is_core);
    longint unsigned n;
    longint unsigned au;
    n  = sz[1] ? 4 : (sz[0] ? 2 : 1);
    au = longint'(a);
    if (is_core && we && a == UART_TX_ADDR) return 1'b1;
    if (au < longint'(DMEM_BASE)) return 1'b0;
    if (au - longint'(DMEM_BASE) + n > longint'(DMEM_BYTES)) return 1'b0;
    return (au % n) == 0;
  endfunction

  task automatic model_reset();
    dma_wait = 0;
    exp_c_v = 0; exp_c_err = 0; exp_d_v = 0; exp_d_err = 0;
    c_hold = '0; d_hold = '0;
    c_pend = 0; d_pend = 0;
  endtask

  // One clock: predict, check at the falling edge, advance the model, then step past the rising edge.
  task automatic cycle();
    bit wc, wd, ok, we;
    logic [31:0] a, wdat, word;
    logic [1:0] sz;
    wc = 0; wd = 0;
    if (dma_req && dma_wait == SMAX) wd = 1;
    else if (core_req) wc = 1;
    else if (dma_req) wd = 1;
    we   = wd ? dma_we    : core_we;
    a    = wd ? dma_addr  : core_addr;
    wdat = wd ? dma_wdata : core_wdata;
    sz   = wd ? dma_size  : core_size;
    ok   = legal(a, sz, we, wc);
    word = mem_word(a);
    @(negedge clk);
    chk1("core_gnt", core_gnt, wc);
    chk1("dma_gnt", dma_gnt, wd);
    chk1("mem_read", mem_read, (wc || wd) && ok && !we);
    chk1("mem_write", mem_write, (wc || wd) && ok && we);
    if ((wc || wd) && ok) begin
      chk("mem_addr", mem_addr, a);
      chk("mem_size", 32'(mem_size), 32'(sz));
      if (we) chk("mem_wdata", mem_wdata, wdat);
    end
    chk1("core_rvalid", core_rvalid, exp_c_v);
    chk1("core_err", core_err, exp_c_v && exp_c_err);
    if (exp_c_v) chk("core_rdata", core_rdata, c_hold);
    chk1("dma_rvalid", dma_rvalid, exp_d_v);
    chk1("dma_err", dma_err, exp_d_v && exp_d_err);
    if (exp_d_v) chk("dma_rdata", dma_rdata, d_hold);
    obs_dgnt = dma_gnt;
    exp_c_v = wc; exp_c_err = wc && !ok;
    exp_d_v = wd; exp_d_err = wd && !ok;
    if (wc) c_hold = !ok ? 32'd0 : (we ? c_hold : word);
    if (wd) d_hold = !ok ? 32'd0 : (we ? d_hold : word);
    if (dma_req && !wd) dma_wait = (dma_wait < SMAX) ? dma_wait + 1 : SMAX;
    else dma_wait = 0;
    if (wc) c_pend = 0;
    if (wd) d_pend = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz);
    core_req = 1; core_we = we; core_addr = a; core_wdata = d; core_size = sz; core_signed = 0;
  endtask

  task automatic set_dma(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; dma_size = sz; dma_signed = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return DMEM_BASE + 32'($urandom_range(0, 255)) * 4;
      1:       return DMEM_BASE + DMEM_BYTES - 32'($urandom_range(0, 6));
      2:       return DMEM_BASE - 32'($urandom_range(1, 4));
      3:       return UART_TX_ADDR;
      4:       return DMEM_BASE + 32'($urandom_range(0, 1023));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dgnts;
    bit exp_core, prev_v, prev_core;
    rst = 1;
    core_req = 1; core_we = 0; core_addr = 32'h1000_0000; core_wdata = 0; core_size = SZ_W;
    core_signed = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h1000_0004; dma_wdata = 0; dma_size = SZ_W;
    dma_signed = 0;
    rr_core_req = 0; rr_dma_req = 0;
    #2;
    // Reset state: requests present but nothing granted or returned.
    chk1("rst_core_gnt", core_gnt, 1'b0);
    chk1("rst_dma_gnt", dma_gnt, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_core_rvalid", core_rvalid, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 0; model_reset();
    core_req = 0; dma_req = 0;

    // Store then load back a word.
    set_core(1, 32'h1000_0004, 32'hDEAD_BEEF, SZ_W); cycle();
    set_core(0, 32'h1000_0004, 32'd0, SZ_W); cycle();
    chk1("t1_rvalid", core_rvalid, 1'b1);
    chk("t1_rdata", core_rdata, 32'hDEAD_BEEF);
    core_req = 0; cycle();

    // Continuous contention under core priority: dma forced in every fifth cycle.
    set_core(0, 32'h1000_0010, 32'd0, SZ_W);
    set_dma(0, 32'h1000_0020, 32'd0, SZ_W);
    dgnts = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      dgnts += int'(obs_dgnt);
    end
    chk("t2_dma_grants", 32'(dgnts), 32'd2);
    core_req = 0; dma_req = 0; cycle();

    // Misaligned dma halfword load.
    set_dma(0, 32'h1000_0003, 32'd0, SZ_H); cycle();
    chk1("t4_dma_err", dma_err, 1'b1);
    chk("t4_dma_rdata", dma_rdata, 32'd0);
    dma_req = 0; cycle();

    // UART: legal core byte store, illegal dma word store.
    set_core(1, UART_TX_ADDR, 32'h0000_0041, SZ_B); cycle();
    core_req = 0; set_dma(1, UART_TX_ADDR, 32'h1234_5678, SZ_W); cycle();
    dma_req = 0; cycle();

    // Random traffic, requests held until granted.
    c_pend = 0; d_pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!c_pend) begin
        if ($urandom_range(0, 3) != 0) begin
          set_core(1'($urandom_range(0, 1)), rand_addr(), $urandom, 2'($urandom_range(0, 3)));
          c_pend = 1;
        end else core_req = 0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          set_dma(1'($urandom_range(0, 1)), rand_addr(), $urandom, 2'($urandom_range(0, 3)));
          d_pend = 1;
        end else dma_req = 0;
      end
      cycle();
    end

    // Reset during a load response drops it; core wins first after release.
    dma_req = 0; set_core(0, 32'h1000_0008, 32'd0, SZ_W); cycle();
    rst = 1;
    #2;
    chk1("t6_core_rvalid", core_rvalid, 1'b0);
    chk1("t6_core_gnt", core_gnt, 1'b0);
    chk1("t6_mem_read", mem_read, 1'b0);
    @(posedge clk); #1;
    rst = 0; model_reset();
    set_dma(0, 32'h1000_000C, 32'd0, SZ_W); cycle();
    core_req = 0; dma_req = 0; cycle();

    // Round robin: strict alternation starting with core, responses at the right port.
    rr_core_req = 1; rr_dma_req = 1;
    exp_core = 1; prev_v = 0; prev_core = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("rr_core_gnt", rr_core_gnt, exp_core);
      chk1("rr_dma_gnt", rr_dma_gnt, !exp_core);
      chk1("rr_core_rvalid", rr_core_rvalid, prev_v && prev_core);
      chk1("rr_dma_rvalid", rr_dma_rvalid, prev_v && !prev_core);
      if (prev_v && prev_core) chk("rr_core_rdata", rr_core_rdata, 32'h1000_0040 ^ 32'h5A5A_5A5A);
      if (prev_v && !prev_core) chk("rr_dma_rdata", rr_dma_rdata, 32'h1000_0080 ^ 32'h5A5A_5A5A);
      prev_v = 1; prev_core = exp_core; exp_core = !exp_core;
      @(posedge clk); #1;
    end
    rr_core_req = 0; rr_dma_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
